ws2812_rx_chain: RTL and testbench

//  Synthesisable, clocked WS2812-style pixel receiver and forwarder; successor to the behavioural LED model.

---
 rtl/ws2812_rx_chain_pkg.sv | 21 ++
 rtl/ws2812_rx_chain_pulse_meas.sv | 66 ++++++
 rtl/ws2812_rx_chain.sv | 128 ++++++++++++
 tb/tb_ws2812_rx_chain.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_rx_chain_pkg.sv
// Shared definitions for the WS2812 receive/forward node: FSM encodings,
// default 100 MHz timing windows and the pulse-validity helper.
package ws2812_rx_chain_pkg;

  localparam logic [0:0] ST_CAPTURE = 1'b0;
  localparam logic [0:0] ST_FORWARD = 1'b1;

  localparam int DEF_BITS         = 24;
  localparam int DEF_T_MIN_CYC    = 15;
  localparam int DEF_T_THRESH_CYC = 53;
  localparam int DEF_T_MAX_CYC    = 100;
  localparam int DEF_T_RESET_CYC  = 5000;

  // A high pulse is usable only inside [t_min, t_max).
  function automatic logic pulse_ok(input int unsigned hi,
                                    input int unsigned t_min,
                                    input int unsigned t_max);
    return (hi >= t_min) && (hi < t_max);
  endfunction

endpackage

// File: rtl/ws2812_rx_chain_pulse_meas.sv
// Input conditioning for the WS2812 node: 2-FF synchroniser, edge detect,
// saturating high/low pulse counters and the one-shot latch-gap event.
module ws2812_rx_chain_pulse_meas #(
  parameter int T_MAX_CYC   = 100,
  parameter int T_RESET_CYC = 5000,
  localparam int CW         = $clog2(T_RESET_CYC + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_serial,
  output logic          o_s,
  output logic          o_fall,
  output logic          o_gap,
  output logic [CW-1:0] o_hi_cnt
);

  localparam logic [CW-1:0] HI_MAX = CW'(T_MAX_CYC);
  localparam logic [CW-1:0] LO_MAX = CW'(T_RESET_CYC);

  logic          sync1_q;
  logic          s_q;
  logic          s_dly_q;
  logic          rise;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;

  assign rise = s_q & ~s_dly_q;

  // hi_cnt restarts at 1 on the rise so that on the fall it equals the pulse width.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (s_q) begin
      lo_cnt_d = '0;
      if (rise) begin
        hi_cnt_d = CW'(1);
      end else if (hi_cnt_q != HI_MAX) begin
        hi_cnt_d = hi_cnt_q + 1'b1;
      end
    end else if (lo_cnt_q != LO_MAX) begin
      lo_cnt_d = lo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_dly_q  <= 1'b0;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      sync1_q  <= i_serial;
      s_q      <= sync1_q;
      s_dly_q  <= s_q;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign o_s      = s_q;
  assign o_fall   = ~s_q & s_dly_q;
  assign o_gap    = ~s_q & (lo_cnt_q == LO_MAX - 1'b1);
  assign o_hi_cnt = hi_cnt_q;

endmodule

// File: rtl/ws2812_rx_chain.sv
// WS2812-style chain node: captures the first BITS valid bits after a latch
// gap, forwards everything after that, and latches the pixel on the next gap.
module ws2812_rx_chain
  import ws2812_rx_chain_pkg::*;
#(
  parameter int BITS         = DEF_BITS,
  parameter int T_MIN_CYC    = DEF_T_MIN_CYC,
  parameter int T_THRESH_CYC = DEF_T_THRESH_CYC,
  parameter int T_MAX_CYC    = DEF_T_MAX_CYC,
  parameter int T_RESET_CYC  = DEF_T_RESET_CYC
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_serial,
  input  logic            i_err_clr,
  output logic            o_serial,
  output logic [BITS-1:0] o_led,
  output logic            o_led_valid,
  output logic            o_err,
  output logic            o_fwd
);

  localparam int CW  = $clog2(T_RESET_CYC + 1);
  localparam int BCW = $clog2(BITS + 1);

  if (!(0 < T_MIN_CYC && T_MIN_CYC < T_THRESH_CYC &&
        T_THRESH_CYC < T_MAX_CYC && T_MAX_CYC < T_RESET_CYC)) begin : g_bad_timing
    $error("ws2812_rx_chain: timing parameters must satisfy 0 < MIN < THRESH < MAX < RESET");
  end

  logic          s;
  logic          fall;
  logic          gap;
  logic [CW-1:0] hi_cnt;
  logic          bit_ok;
  logic          bit_val;

  logic [0:0]      state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0] led_q, led_d;
  logic            led_valid_q, led_valid_d;
  logic            err_q, err_d;
  logic            serial_q, serial_d;
  logic            fwd_q, fwd_d;

  ws2812_rx_chain_pulse_meas #(
    .T_MAX_CYC  (T_MAX_CYC),
    .T_RESET_CYC(T_RESET_CYC)
  ) u_meas (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_serial(i_serial),
    .o_s     (s),
    .o_fall  (fall),
    .o_gap   (gap),
    .o_hi_cnt(hi_cnt)
  );

  assign bit_ok  = pulse_ok(32'(hi_cnt), T_MIN_CYC, T_MAX_CYC);
  assign bit_val = (32'(hi_cnt) >= T_THRESH_CYC);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    led_d       = led_q;
    led_valid_d = 1'b0;
    err_d       = err_q;
    serial_d    = (state_q == ST_FORWARD) ? s : 1'b0;

    // Clear first so that an error detected in the same cycle wins.
    if (i_err_clr) err_d = 1'b0;

    if (fall) begin
      if (!bit_ok) begin
        err_d = 1'b1;
      end else if (state_q == ST_CAPTURE) begin
        shift_d   = {shift_q[BITS-2:0], bit_val};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BCW'(BITS - 1)) state_d = ST_FORWARD;
      end
    end

    if (gap) begin
      if (bit_cnt_q == BCW'(BITS)) begin
        led_d       = shift_q;
        led_valid_d = 1'b1;
      end else if (bit_cnt_q != '0) begin
        err_d = 1'b1;
      end
      state_d   = ST_CAPTURE;
      bit_cnt_d = '0;
      serial_d  = 1'b0;
    end

    fwd_d = (state_d == ST_FORWARD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_CAPTURE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      led_q       <= '0;
      led_valid_q <= 1'b0;
      err_q       <= 1'b0;
      serial_q    <= 1'b0;
      fwd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      led_q       <= led_d;
      led_valid_q <= led_valid_d;
      err_q       <= err_d;
      serial_q    <= serial_d;
      fwd_q       <= fwd_d;
    end
  end

  assign o_serial    = serial_q;
  assign o_led       = led_q;
  assign o_led_valid = led_valid_q;
  assign o_err       = err_q;
  assign o_fwd       = fwd_q;

endmodule

// File: tb/tb_ws2812_rx_chain.sv
// Bench for ws2812_rx_chain: two 24-bit nodes chained plus one stand-alone
// 32-bit node, checked against a pulse-level model of the chain.
`timescale 1ns/1ps
module tb_ws2812_rx_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ser0, ser2, err_clr;
  logic        ser01, ser1_out, ser2_out;
  logic [23:0] led0, led1;
  logic [31:0] led2;
  logic        v0, v1, v2, e0, e1, e2, f0, f1, f2;

  ws2812_rx_chain #(.BITS(24)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser0), .i_err_clr(err_clr),
    .o_serial(ser01), .o_led(led0), .o_led_valid(v0), .o_err(e0), .o_fwd(f0));
  ws2812_rx_chain #(.BITS(24)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser01), .i_err_clr(err_clr),
    .o_serial(ser1_out), .o_led(led1), .o_led_valid(v1), .o_err(e1), .o_fwd(f1));
  ws2812_rx_chain #(.BITS(32)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser2), .i_err_clr(err_clr),
    .o_serial(ser2_out), .o_led(led2), .o_led_valid(v2), .o_err(e2), .o_fwd(f2));

  int vc0 = 0, vc1 = 0, vc2 = 0;
  always @(posedge clk) begin
    if (v0) vc0 <= vc0 + 1;
    if (v1) vc1 <= vc1 + 1;
    if (v2) vc2 <= vc2 + 1;
  end

  // Chain model: per node, valid bits captured so far and the expected outputs.
  int          cnt[2];
  logic [23:0] sh[2];
  logic [23:0] led_exp[2];
  logic        err_exp[2];
  int          strobe_new[2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; sh[k] = '0; led_exp[k] = '0; err_exp[k] = 1'b0; strobe_new[k] = 0;
    end
  endtask

  // A pulse reaches node k only if every node before it is already full.
  task automatic model_pulse(input int hi_ns);
    bit ok;
    bit b;
    ok = (hi_ns >= 150) && (hi_ns < 1000);
    b  = (hi_ns >= 525);
    for (int k = 0; k < 2; k++) begin
      if (!ok) begin
        err_exp[k] = 1'b1;
        if (cnt[k] < 24) break;
      end else if (cnt[k] < 24) begin
        sh[k] = {sh[k][22:0], b};
        cnt[k]++;
        break;
      end
    end
  endtask

  task automatic model_gap();
    for (int k = 0; k < 2; k++) begin
      strobe_new[k] = 0;
      if (cnt[k] == 24) begin
        led_exp[k] = sh[k];
        strobe_new[k] = 1;
      end else if (cnt[k] > 0) begin
        err_exp[k] = 1'b1;
      end
      cnt[k] = 0;
    end
  endtask

  task automatic pulse0(input int hi_ns, input int lo_ns);
    model_pulse(hi_ns);
    ser0 = 1'b1; #(hi_ns);
    ser0 = 1'b0; #(lo_ns);
  endtask

  task automatic pulse2(input int hi_ns, input int lo_ns);
    ser2 = 1'b1; #(hi_ns);
    ser2 = 1'b0; #(lo_ns);
  endtask

  task automatic bit_fixed(input bit b, input int t1h, input int t1l, input int t0h, input int t0l);
    if (b) pulse0(t1h, t1l);
    else   pulse0(t0h, t0l);
  endtask

  task automatic bit_rand(input bit b);
    if (b) pulse0(10 * $urandom_range(62, 85), 10 * $urandom_range(45, 70));
    else   pulse0(10 * $urandom_range(25, 42), 10 * $urandom_range(60, 90));
  endtask

  task automatic word_rand(input logic [23:0] w, input int first, input int last);
    for (int i = first; i >= last; i--) bit_rand(w[i]);
  endtask

  task automatic gap_and_check(input string tag);
    int s0;
    int s1;
    s0 = vc0;
    s1 = vc1;
    model_gap();
    #55000;
    @(negedge clk);
    chk({tag, " led0"}, 32'(led0), 32'(led_exp[0]));
    chk({tag, " led1"}, 32'(led1), 32'(led_exp[1]));
    chk({tag, " strobes0"}, 32'(vc0 - s0), 32'(strobe_new[0]));
    chk({tag, " strobes1"}, 32'(vc1 - s1), 32'(strobe_new[1]));
    chk({tag, " err0"}, 32'(e0), 32'(err_exp[0]));
    chk({tag, " err1"}, 32'(e1), 32'(err_exp[1]));
    chk({tag, " fwd0"}, 32'(f0), 32'd0);
    chk({tag, " fwd1"}, 32'(f1), 32'd0);
  endtask

  initial begin
    logic [23:0] px;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [31:0] w32;
    int          k;
    int          s2;

    rst_n = 1'b0; ser0 = 1'b0; ser2 = 1'b0; err_clr = 1'b0;
    model_reset();
    #23;
    chk("reset led0", 32'(led0), 32'd0);
    chk("reset led2", 32'(led2), 32'd0);
    chk("reset err0", 32'(e0), 32'd0);
    chk("reset valid0", 32'(v0), 32'd0);
    chk("reset fwd0", 32'(f0), 32'd0);
    chk("reset serial0", 32'(ser01), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #103;

    // Nominal timing, same pixel to both nodes.
    px = 24'hF0F0FF;
    for (int i = 23; i >= 0; i--) bit_fixed(px[i], 700, 600, 350, 800);
    chk("t1 fwd0 after 24", 32'(f0), 32'd1);
    chk("t1 fwd1 after 24", 32'(f1), 32'd0);
    for (int i = 23; i >= 0; i--) bit_fixed(px[i], 700, 600, 350, 800);
    chk("t1 fwd1 after 48", 32'(f1), 32'd1);
    gap_and_check("t1");

    // Skewed timing close to the decision threshold.
    for (int r = 0; r < 2; r++)
      for (int i = 23; i >= 0; i--) bit_fixed(px[i], 550, 450, 500, 950);
    gap_and_check("t2");

    // 32-bit stand-alone node.
    w32 = 32'hDEADBEEF;
    s2 = vc2;
    for (int i = 31; i >= 0; i--) begin
      if (i == 0) chk("t3 fwd2 after 31", 32'(f2), 32'd0);
      if (w32[i]) pulse2(700, 600);
      else        pulse2(350, 800);
    end
    chk("t3 fwd2 after 32", 32'(f2), 32'd1);
    #55000;
    @(negedge clk);
    chk("t3 led2", led2, 32'hDEADBEEF);
    chk("t3 strobes2", 32'(vc2 - s2), 32'd1);
    chk("t3 err2", 32'(e2), 32'd0);
    chk("t3 fwd2 after gap", 32'(f2), 32'd0);

    // Short frame: pixel held, error raised, then cleared.
    p0 = 24'($urandom);
    word_rand(p0, 23, 4);
    gap_and_check("t4");
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    err_exp[0] = 1'b0; err_exp[1] = 1'b0;
    chk("t4 err0 cleared", 32'(e0), 32'd0);

    // Glitch inside the first pixel, random pixels and jitter.
    p0 = 24'($urandom) | 24'h1;
    p1 = 24'($urandom);
    k  = $urandom_range(1, 22);
    word_rand(p0, 23, 24 - k);
    pulse0(100, 300);
    word_rand(p0, 23 - k, 0);
    word_rand(p1, 23, 0);
    gap_and_check("t5");

    // Reset in the middle of a high pulse.
    word_rand(24'($urandom), 23, 14);
    ser0 = 1'b1;
    #203;
    rst_n = 1'b0;
    #1;
    chk("t6 led0 async", 32'(led0), 32'd0);
    chk("t6 led1 async", 32'(led1), 32'd0);
    chk("t6 led2 async", led2, 32'd0);
    chk("t6 err0 async", 32'(e0), 32'd0);
    chk("t6 fwd0 async", 32'(f0), 32'd0);
    chk("t6 serial0 async", 32'(ser01), 32'd0);
    model_reset();
    ser0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1000;
    for (int r = 0; r < 2; r++)
      for (int i = 23; i >= 0; i--) bit_fixed(px[i], 700, 600, 350, 800);
    gap_and_check("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
